io_device_port: RTL and testbench

IO_DEVICE_PORT -- requirements
Module: io_device_port

---
 rtl/io_device_port.sv | 166 ++++++++++++++++
 tb/tb_io_device_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_device_port.sv
// Host byte port bridging a TX and an RX FIFO to a processor's four-phase input and timed-capture output handshakes.
// Optional statistics counters are built only when IO_DEV_STATS_EN is defined.
module io_device_port #(
  parameter int DEPTH       = 4,
  parameter int CAPTURE_DLY = 2
) (
  input  logic       g_clk,
  input  logic       g_clr,
  input  logic       host_wr_en,
  input  logic [7:0] host_wr_data,
  output logic       host_full,
  input  logic       host_rd_en,
  output logic [7:0] host_rd_data,
  output logic       host_empty,
  output logic [7:0] dev_data,
  output logic       dev_hs,
  input  logic       proc_ack,
  input  logic [7:0] proc_out_data,
  output logic       out_rdy,
  output logic       out_ack,
  output logic [7:0] tx_count,
  output logic [7:0] rx_count,
  output logic [1:0] o_in_state,
  output logic [1:0] o_out_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0]    DLY_LAST = 3'(CAPTURE_DLY - 1);

  localparam logic [1:0] I_IDLE    = 2'd0;
  localparam logic [1:0] I_PRESENT = 2'd1;
  localparam logic [1:0] I_RELEASE = 2'd2;

  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_WAIT = 2'd1;
  localparam logic [1:0] O_ACK  = 2'd2;
  localparam logic [1:0] O_HOLD = 2'd3;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp, r_tx_rp;
  logic [CW-1:0] r_tx_cnt;
  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp, r_rx_rp;
  logic [CW-1:0] r_rx_cnt;

  logic [1:0] r_in_state, r_out_state;
  logic [2:0] r_dly;
  logic [7:0] r_dev_data;

  logic w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;

  assign w_tx_full  = (r_tx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_rx_empty = (r_rx_cnt == '0);

  // Input side is four-phase: dev_hs rises with stable dev_data, proc_ack rise consumes
  // the byte and drops dev_hs, proc_ack fall completes the cycle. Output side raises
  // out_rdy, samples proc_out_data CAPTURE_DLY cycles later, then pulses out_ack once.
  assign w_tx_push = host_wr_en && !w_tx_full && !g_clr;
  assign w_tx_pop  = (r_in_state == I_PRESENT) && proc_ack && !w_tx_empty;
  assign w_rx_push = (r_out_state == O_WAIT) && (r_dly == DLY_LAST) && !w_rx_full;
  assign w_rx_pop  = host_rd_en && !w_rx_empty && !g_clr;

  always_ff @(posedge g_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= host_wr_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= proc_out_data;
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CW'(1);
        2'b01:   r_tx_cnt <= r_tx_cnt - CW'(1);
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CW'(1);
        2'b01:   r_rx_cnt <= r_rx_cnt - CW'(1);
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      r_in_state <= I_IDLE;
      r_dev_data <= 8'd0;
    end else begin
      case (r_in_state)
        I_IDLE: if (!w_tx_empty) begin
          r_in_state <= I_PRESENT;
          r_dev_data <= r_tx_mem[r_tx_rp];
        end
        I_PRESENT: if (proc_ack) r_in_state <= I_RELEASE;
        I_RELEASE: if (!proc_ack) r_in_state <= I_IDLE;
        default:   r_in_state <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      r_out_state <= O_IDLE;
      r_dly       <= 3'd0;
    end else begin
      case (r_out_state)
        O_IDLE: if (!w_rx_full) begin
          r_out_state <= O_WAIT;
          r_dly       <= 3'd0;
        end
        O_WAIT: begin
          if (r_dly == DLY_LAST) r_out_state <= O_ACK;
          else                   r_dly       <= r_dly + 3'd1;
        end
        O_ACK:   r_out_state <= O_HOLD;
        O_HOLD:  r_out_state <= O_IDLE;
        default: r_out_state <= O_IDLE;
      endcase
    end
  end

`ifdef IO_DEV_STATS_EN
  logic [7:0] r_tx_count, r_rx_count;

  // Counters wrap naturally at 255; a reset-aborted transfer never reaches the pop/push.
  always_ff @(posedge g_clk) begin
    if (g_clr) begin
      r_tx_count <= 8'd0;
      r_rx_count <= 8'd0;
    end else begin
      if (w_tx_pop)  r_tx_count <= r_tx_count + 8'd1;
      if (w_rx_push) r_rx_count <= r_rx_count + 8'd1;
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`else
  assign tx_count = 8'd0;
  assign rx_count = 8'd0;
`endif

  assign host_full    = w_tx_full;
  assign host_empty   = w_rx_empty;
  assign host_rd_data = r_rx_mem[r_rx_rp];
  assign dev_data     = r_dev_data;
  assign dev_hs       = (r_in_state == I_PRESENT);
  assign out_rdy      = (r_out_state == O_WAIT);
  assign out_ack      = (r_out_state == O_ACK);
  assign o_in_state   = r_in_state;
  assign o_out_state  = r_out_state;
endmodule

// File: tb/tb_io_device_port.sv
// Directed self-checking bench for io_device_port (DEPTH=4, CAPTURE_DLY=2); honours IO_DEV_STATS_EN.
module tb_io_device_port;
  logic       g_clk = 1'b0;
  logic       g_clr, host_wr_en, host_rd_en, proc_ack;
  logic [7:0] host_wr_data, proc_out_data;
  logic       host_full, host_empty, dev_hs, out_rdy, out_ack;
  logic [7:0] host_rd_data, dev_data, tx_count, rx_count;
  logic [1:0] o_in_state, o_out_state;

  int checks = 0;
  int errors = 0;

`ifdef IO_DEV_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 g_clk = ~g_clk;

  io_device_port #(.DEPTH(4), .CAPTURE_DLY(2)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .host_full(host_full),
    .host_rd_en(host_rd_en), .host_rd_data(host_rd_data), .host_empty(host_empty),
    .dev_data(dev_data), .dev_hs(dev_hs), .proc_ack(proc_ack),
    .proc_out_data(proc_out_data), .out_rdy(out_rdy), .out_ack(out_ack),
    .tx_count(tx_count), .rx_count(rx_count),
    .o_in_state(o_in_state), .o_out_state(o_out_state)
  );

  task automatic tick;
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset;
    g_clr = 1'b1; host_wr_en = 1'b0; host_rd_en = 1'b0; proc_ack = 1'b0;
    tick; tick;
    g_clr = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    host_wr_data = b; host_wr_en = 1'b1;
    tick;
    host_wr_en = 1'b0;
  endtask

  // Waits (bounded) for dev_hs, takes the byte, then runs the ack rise/fall.
  task automatic handshake(output logic [7:0] got);
    int n = 0;
    while (dev_hs !== 1'b1 && n < 20) begin tick; n++; end
    checks++;
    if (dev_hs !== 1'b1) begin
      errors++; $display("FAIL hs_timeout dev_hs=%b required 1", dev_hs); got = 8'hxx;
    end else got = dev_data;
    proc_ack = 1'b1; tick;
    checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL hs_release dev_hs=%b required 0", dev_hs); end
    proc_ack = 1'b0; tick;
  endtask

  task automatic test_reset;
    g_clr = 1'b1; host_wr_en = 1'b1; host_wr_data = 8'hEE; host_rd_en = 1'b1; proc_ack = 1'b0;
    proc_out_data = 8'h00;
    tick; tick;
    checks++; if (dev_data !== 8'h00) begin errors++; $display("FAIL rst_dev_data got %h required 00", dev_data); end
    checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL rst_dev_hs got %b required 0", dev_hs); end
    checks++; if (out_rdy !== 1'b0) begin errors++; $display("FAIL rst_out_rdy got %b required 0", out_rdy); end
    checks++; if (out_ack !== 1'b0) begin errors++; $display("FAIL rst_out_ack got %b required 0", out_ack); end
    checks++; if (tx_count !== 8'd0) begin errors++; $display("FAIL rst_tx_count got %0d required 0", tx_count); end
    checks++; if (rx_count !== 8'd0) begin errors++; $display("FAIL rst_rx_count got %0d required 0", rx_count); end
    checks++; if (host_empty !== 1'b1) begin errors++; $display("FAIL rst_host_empty got %b required 1", host_empty); end
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL rst_host_full got %b required 0", host_full); end
    checks++; if (o_in_state !== 2'd0 || o_out_state !== 2'd0) begin
      errors++; $display("FAIL rst_states got %0d/%0d required 0/0", o_in_state, o_out_state);
    end
    g_clr = 1'b0; host_wr_en = 1'b0; host_rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL rst_push_ignored dev_hs=%b required 0", dev_hs); end
    end
  endtask

  task automatic test_single;
    do_reset;
    push_byte(8'h5A);
    tick;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dev_hs !== 1'b1 || dev_data !== 8'h5A) begin
        errors++; $display("FAIL single_hold cyc %0d dev_hs=%b dev_data=%h required 1/5a", i, dev_hs, dev_data);
      end
      tick;
    end
    proc_ack = 1'b1; tick;
    checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL single_drop dev_hs=%b required 0", dev_hs); end
    checks++; if (dev_data !== 8'h5A) begin errors++; $display("FAIL single_keep dev_data=%h required 5a", dev_data); end
    checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL single_full host_full=%b required 0", host_full); end
    tick;
    checks++; if (o_in_state !== 2'd2) begin errors++; $display("FAIL single_release state=%0d required 2", o_in_state); end
    proc_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL single_popped dev_hs=%b required 0", dev_hs); end
    end
  endtask

  task automatic test_full;
    logic [7:0] vals [4];
    logic [7:0] got;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset;
    for (int i = 0; i < 4; i++) push_byte(vals[i]);
    checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL full_after4 host_full=%b required 1", host_full); end
    push_byte(8'h55);
    checks++; if (host_full !== 1'b1) begin errors++; $display("FAIL full_drop host_full=%b required 1", host_full); end
    for (int i = 0; i < 4; i++) begin
      handshake(got);
      checks++; if (got !== vals[i]) begin errors++; $display("FAIL full_order %0d got %h required %h", i, got, vals[i]); end
      if (i == 0) begin
        checks++; if (host_full !== 1'b0) begin errors++; $display("FAIL full_release host_full=%b required 0", host_full); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL full_55_dropped dev_hs=%b dev_data=%h required 0", dev_hs, dev_data); end
    end
  endtask

  task automatic test_capture;
    logic [6:0] exp_rdy, exp_ack, exp_emp;
    exp_rdy = 7'b1100011;  // bit t-1 holds the value after edge t
    exp_ack = 7'b0000100;
    exp_emp = 7'b0000011;
    proc_out_data = 8'hC3;
    do_reset;
    for (int t = 1; t <= 7; t++) begin
      tick;
      checks++;
      if (out_rdy !== exp_rdy[t-1] || out_ack !== exp_ack[t-1] || host_empty !== exp_emp[t-1]) begin
        errors++;
        $display("FAIL cap_seq t%0d rdy/ack/empty=%b%b%b required %b%b%b", t, out_rdy, out_ack, host_empty,
                 exp_rdy[t-1], exp_ack[t-1], exp_emp[t-1]);
      end
      if (t == 3) begin
        checks++; if (host_rd_data !== 8'hC3) begin errors++; $display("FAIL cap_data got %h required c3", host_rd_data); end
        proc_out_data = 8'h3C;
      end
    end
    host_rd_en = 1'b1; tick; host_rd_en = 1'b0;
    checks++; if (out_ack !== 1'b1) begin errors++; $display("FAIL cap2_ack got %b required 1", out_ack); end
    checks++; if (host_empty !== 1'b0) begin errors++; $display("FAIL cap_pushpop_empty got %b required 0", host_empty); end
    checks++; if (host_rd_data !== 8'h3C) begin errors++; $display("FAIL cap_pushpop_head got %h required 3c", host_rd_data); end
    checks++; if (rx_count !== (STATS ? 8'd2 : 8'd0)) begin errors++; $display("FAIL cap_rx_count got %0d required %0d", rx_count, STATS ? 2 : 0); end
    host_rd_en = 1'b1; tick; host_rd_en = 1'b0;
    checks++; if (host_empty !== 1'b1) begin errors++; $display("FAIL cap_pushpop_count host_empty=%b required 1", host_empty); end
  endtask

  task automatic test_rx_full;
    int n;
    proc_out_data = 8'hA0;
    do_reset;
    for (int t = 0; t < 40; t++) begin
      tick;
      if (out_ack === 1'b1) proc_out_data = proc_out_data + 8'd1;
    end
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_rdy !== 1'b0 || o_out_state !== 2'd0) begin
        errors++; $display("FAIL rxfull_idle out_rdy=%b state=%0d required 0/0", out_rdy, o_out_state);
      end
      tick;
    end
    checks++; if (host_rd_data !== 8'hA0) begin errors++; $display("FAIL rxfull_head got %h required a0", host_rd_data); end
    checks++; if (rx_count !== (STATS ? 8'd4 : 8'd0)) begin errors++; $display("FAIL rxfull_rx_count got %0d required %0d", rx_count, STATS ? 4 : 0); end
    host_rd_en = 1'b1; tick; host_rd_en = 1'b0;
    checks++; if (out_rdy !== 1'b0 || host_rd_data !== 8'hA1) begin
      errors++; $display("FAIL rxfull_pop out_rdy=%b head=%h required 0/a1", out_rdy, host_rd_data);
    end
    tick;
    checks++; if (out_rdy !== 1'b1) begin errors++; $display("FAIL rxfull_resume out_rdy=%b required 1", out_rdy); end
    n = 0;
    while (out_ack !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (out_ack !== 1'b1) begin errors++; $display("FAIL rxfull_ack_timeout out_ack=%b required 1", out_ack); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (host_rd_data !== 8'hA1 + 8'(i)) begin
        errors++; $display("FAIL rxfull_drain %0d got %h required %h", i, host_rd_data, 8'hA1 + 8'(i));
      end
      host_rd_en = 1'b1; tick;
    end
    host_rd_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] got;
    int n;
    do_reset;
    push_byte(8'h71); push_byte(8'h72); push_byte(8'h73);
    handshake(got);
    checks++; if (got !== 8'h71) begin errors++; $display("FAIL mid_first got %h required 71", got); end
    n = 0;
    while (dev_hs !== 1'b1 && n < 10) begin tick; n++; end
    checks++; if (dev_hs !== 1'b1 || dev_data !== 8'h72) begin
      errors++; $display("FAIL mid_present dev_hs=%b dev_data=%h required 1/72", dev_hs, dev_data);
    end
    checks++; if (tx_count !== (STATS ? 8'd1 : 8'd0)) begin errors++; $display("FAIL mid_tx_count got %0d required %0d", tx_count, STATS ? 1 : 0); end
    g_clr = 1'b1; proc_ack = 1'b1; tick; proc_ack = 1'b0;
    checks++; if ({dev_data, dev_hs, out_rdy, out_ack} !== 11'd0) begin
      errors++; $display("FAIL mid_outputs dev_data=%h hs=%b rdy=%b ack=%b required 0", dev_data, dev_hs, out_rdy, out_ack);
    end
    checks++; if (tx_count !== 8'd0 || rx_count !== 8'd0) begin
      errors++; $display("FAIL mid_counts tx=%0d rx=%0d required 0/0", tx_count, rx_count);
    end
    checks++; if (host_empty !== 1'b1 || host_full !== 1'b0) begin
      errors++; $display("FAIL mid_flags empty=%b full=%b required 1/0", host_empty, host_full);
    end
    g_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if (dev_hs !== 1'b0) begin errors++; $display("FAIL mid_no_hs dev_hs=%b required 0", dev_hs); end
    end
  endtask

  task automatic test_stats;
    logic [7:0] got;
    logic [7:0] exp_cnt;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      push_byte(8'(i));
      handshake(got);
      checks++; if (got !== 8'(i)) begin errors++; $display("FAIL stats_data %0d got %h required %h", i, got, 8'(i)); end
      exp_cnt = STATS ? 8'(i + 1) : 8'd0;
      checks++; if (tx_count !== exp_cnt) begin errors++; $display("FAIL stats_tx_count %0d got %0d required %0d", i, tx_count, exp_cnt); end
      if (i == 99) begin
        checks++; if (rx_count !== (STATS ? 8'd4 : 8'd0)) begin errors++; $display("FAIL stats_rx_count got %0d required %0d", rx_count, STATS ? 4 : 0); end
      end
    end
    checks++; if (tx_count !== 8'd0) begin errors++; $display("FAIL stats_wrap got %0d required 0", tx_count); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    host_wr_data = 8'h00; proc_out_data = 8'h00;
    g_clr = 1'b1; host_wr_en = 1'b0; host_rd_en = 1'b0; proc_ack = 1'b0;
    test_reset;
    test_single;
    test_full;
    test_capture;
    test_rx_full;
    test_reset_mid;
    test_stats;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
